// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage.
// Contents: opcode constants, instruction field positions, the decoded
// field struct and the opcode classification helpers usesSr2/writesDr.
package operand_fetch_stage_pkg;

   localparam int OP_WIDTH  = 4;
   localparam int REG_W     = 4;
   localparam int IMM_W     = 16;

   // Instruction layout: [31:28] op, [27:24] dr, [23:20] sr1, [19:16] sr2, [15:0] imm
   localparam int OP_LSB    = 28;
   localparam int DR_LSB    = 24;
   localparam int SR1_LSB   = 20;
   localparam int SR2_LSB   = 16;
   localparam int IMM_LSB   = 0;

   localparam logic [OP_WIDTH-1:0] OP_LOAD   = 4'hA;
   localparam logic [OP_WIDTH-1:0] OP_STORE  = 4'hB;
   localparam logic [OP_WIDTH-1:0] OP_BRANCH = 4'hC;

   typedef struct packed {
      logic [OP_WIDTH-1:0] op;
      logic [REG_W-1:0]    dr;
      logic [REG_W-1:0]    sr1;
      logic [REG_W-1:0]    sr2;
      logic [IMM_W-1:0]    imm;
   } instr_fields_t;

   // Register-form ops (op[3]=0) read sr2; the store also reads it as its data source.
   function automatic logic usesSr2(input logic [OP_WIDTH-1:0] op);
      return (op[3] == 1'b0) || (op == OP_STORE);
   endfunction

   // Stores and branches are the only ops that do not write a register.
   function automatic logic writesDr(input logic [OP_WIDTH-1:0] op);
      return (op != OP_STORE) && (op != OP_BRANCH);
   endfunction

endpackage

// File: rtl/operand_fetch_stage_pending_scoreboard.sv
// Pending-write scoreboard: one bit per register marks a load in flight.
// Ports: clk, reset_n (async active-low), setEn/setAddr (load accepted),
// clrEn/clrAddr (writeback), rdAddr1/rdAddr2 -> busy1/busy2 lookups.
// A set and a clear of the same register in one cycle leaves it set.
module pending_scoreboard #(
   parameter int REG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 setEn,
   input  logic [REG_WIDTH-1:0] setAddr,
   input  logic                 clrEn,
   input  logic [REG_WIDTH-1:0] clrAddr,
   input  logic [REG_WIDTH-1:0] rdAddr1,
   input  logic [REG_WIDTH-1:0] rdAddr2,
   output logic                 busy1,
   output logic                 busy2
);

   localparam int REG_SIZE = 1 << REG_WIDTH;

   logic [REG_SIZE-1:0] pending_r;

   // Per-register set/clear update, set has priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_r <= '0;
      end else begin
         for (int i = 0; i < REG_SIZE; i++) begin
            if (setEn && (setAddr == REG_WIDTH'(i))) begin
               pending_r[i] <= 1'b1;
            end else if (clrEn && (clrAddr == REG_WIDTH'(i))) begin
               pending_r[i] <= 1'b0;
            end else begin
               pending_r[i] <= pending_r[i];
            end
         end
      end
   end

   assign busy1 = pending_r[rdAddr1];
   assign busy2 = pending_r[rdAddr2];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: decodes the instruction, drives register file read
// addresses, captures operands into a one-entry valid/ready register and
// stalls consumers of loads still in flight.
// Ports: clk/reset_n; fetch side inValid/inReady/inInstr/inPc; flush;
// register file sr1/sr2 -> sr1Out/sr2Out; writeback wrtEn/dr/dIn;
// execute side outValid/outReady and the held out* fields.
// Build option: define BYPASS_EN for writeback-to-operand bypass; without
// it a source matching the current writeback stalls one cycle instead.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int REG_WIDTH = 4,
   parameter int IMM_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [BIT_WIDTH-1:0] inInstr,
   input  logic [BIT_WIDTH-1:0] inPc,
   input  logic                 flush,
   output logic [REG_WIDTH-1:0] sr1,
   output logic [REG_WIDTH-1:0] sr2,
   input  logic [BIT_WIDTH-1:0] sr1Out,
   input  logic [BIT_WIDTH-1:0] sr2Out,
   input  logic                 wrtEn,
   input  logic [REG_WIDTH-1:0] dr,
   input  logic [BIT_WIDTH-1:0] dIn,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [3:0]           outOp,
   output logic [REG_WIDTH-1:0] outDr,
   output logic [BIT_WIDTH-1:0] outA,
   output logic [BIT_WIDTH-1:0] outB,
   output logic [BIT_WIDTH-1:0] outImm,
   output logic [BIT_WIDTH-1:0] outPc,
   output logic                 outWrtEn,
   output logic                 outIsLoad
);

   logic [3:0]           op_s;
   logic [REG_WIDTH-1:0] dr_field_s;
   logic [IMM_WIDTH-1:0] imm_s;
   logic [BIT_WIDTH-1:0] imm_ext_s;
   logic                 use_sr2_s;
   logic                 busy1_s;
   logic                 busy2_s;
   logic                 wb_hit1_s;
   logic                 wb_hit2_s;
   logic                 hazard_s;
   logic                 accept_s;
   logic [BIT_WIDTH-1:0] op_a_s;
   logic [BIT_WIDTH-1:0] op_b_s;

   logic                 valid_r;
   logic [3:0]           op_r;
   logic [REG_WIDTH-1:0] dr_r;
   logic [BIT_WIDTH-1:0] a_r;
   logic [BIT_WIDTH-1:0] b_r;
   logic [BIT_WIDTH-1:0] imm_r;
   logic [BIT_WIDTH-1:0] pc_r;
   logic                 wrt_en_r;
   logic                 is_load_r;

   assign op_s       = inInstr[OP_LSB +: 4];
   assign dr_field_s = inInstr[DR_LSB +: REG_WIDTH];
   assign sr1        = inInstr[SR1_LSB +: REG_WIDTH];
   assign sr2        = inInstr[SR2_LSB +: REG_WIDTH];
   assign imm_s      = inInstr[IMM_LSB +: IMM_WIDTH];
   assign imm_ext_s  = {{(BIT_WIDTH-IMM_WIDTH){imm_s[IMM_WIDTH-1]}}, imm_s};
   assign use_sr2_s  = usesSr2(op_s);

   // A source is "hit" when writeback targets it in this very cycle.
   assign wb_hit1_s  = wrtEn && (dr == sr1);
   assign wb_hit2_s  = wrtEn && (dr == sr2) && use_sr2_s;

   pending_scoreboard #(.REG_WIDTH(REG_WIDTH)) u_scoreboard (
      .clk     (clk),
      .reset_n (reset_n),
      .setEn   (accept_s && (op_s == OP_LOAD)),
      .setAddr (dr_field_s),
      .clrEn   (wrtEn),
      .clrAddr (dr),
      .rdAddr1 (sr1),
      .rdAddr2 (sr2),
      .busy1   (busy1_s),
      .busy2   (busy2_s)
   );

`ifdef BYPASS_EN
   // A pending source released by this cycle's writeback is forwarded, not stalled.
   assign hazard_s = inValid && ((busy1_s && !wb_hit1_s) ||
                                 (use_sr2_s && busy2_s && !wb_hit2_s));
   assign op_a_s   = wb_hit1_s ? dIn : sr1Out;
   assign op_b_s   = use_sr2_s ? (wb_hit2_s ? dIn : sr2Out) : imm_ext_s;
`else
   // Without forwarding, wait until the register file write has landed.
   logic unused_din_s;
   assign unused_din_s = ^dIn;
   assign hazard_s = inValid && (busy1_s || wb_hit1_s ||
                                 (use_sr2_s && (busy2_s || wb_hit2_s)));
   assign op_a_s   = sr1Out;
   assign op_b_s   = use_sr2_s ? sr2Out : imm_ext_s;
`endif

   assign inReady  = (!valid_r || outReady) && !hazard_s && !flush;
   assign accept_s = inValid && inReady;

   // Pipeline register: load on accept, drop on flush or drain, else hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_r   <= 1'b0;
         op_r      <= 4'h0;
         dr_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         imm_r     <= '0;
         pc_r      <= '0;
         wrt_en_r  <= 1'b0;
         is_load_r <= 1'b0;
      end else if (accept_s) begin
         valid_r   <= 1'b1;
         op_r      <= op_s;
         dr_r      <= dr_field_s;
         a_r       <= op_a_s;
         b_r       <= op_b_s;
         imm_r     <= imm_ext_s;
         pc_r      <= inPc;
         wrt_en_r  <= writesDr(op_s);
         is_load_r <= (op_s == OP_LOAD);
      end else if (flush || (valid_r && outReady)) begin
         valid_r   <= 1'b0;
      end else begin
         valid_r   <= valid_r;
      end
   end

   assign outValid  = valid_r;
   assign outOp     = op_r;
   assign outDr     = dr_r;
   assign outA      = a_r;
   assign outB      = b_r;
   assign outImm    = imm_r;
   assign outPc     = pc_r;
   assign outWrtEn  = wrt_en_r;
   assign outIsLoad = is_load_r;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-read stage between instruction fetch and execute.
- Splits the fetched instruction into fields and drives the register file read addresses.
- Captures the read operands into a one-entry valid/ready pipeline register, with a write-through bypass from writeback.
- A pending-write scoreboard stalls any consumer of a load result still in flight.

Parameters:
- BIT_WIDTH, 32, datapath and instruction width.
- REG_WIDTH, 4, register address width; REG_SIZE = 1<<REG_WIDTH scoreboard bits.
- IMM_WIDTH, 16, immediate field width; sign-extended to BIT_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- inValid  in  1  fetch presents an instruction.
- inReady  out  1  stage accepts the instruction this cycle.
- inInstr  in  BIT_WIDTH  instruction word.
- inPc  in  BIT_WIDTH  instruction address.
- flush  in  1  discard the held instruction (branch redirect).
- sr1  out  REG_WIDTH  register file read address 1 (combinational from inInstr).
- sr2  out  REG_WIDTH  register file read address 2.
- sr1Out  in  BIT_WIDTH  register file read data 1.
- sr2Out  in  BIT_WIDTH  register file read data 2.
- wrtEn  in  1  writeback write enable (same net driving the register file).
- dr  in  REG_WIDTH  writeback destination.
- dIn  in  BIT_WIDTH  writeback data.
- outValid  out  1  held instruction valid.
- outReady  in  1  execute accepts.
- outOp  out  4  opcode.
- outDr  out  REG_WIDTH  destination register.
- outA  out  BIT_WIDTH  operand A.
- outB  out  BIT_WIDTH  operand B, or sign-extended immediate.
- outImm  out  BIT_WIDTH  sign-extended immediate.
- outPc  out  BIT_WIDTH  held PC.
- outWrtEn  out  1  instruction writes outDr.
- outIsLoad  out  1  instruction is a load.

Behaviour:
- Instruction format: [31:28] op, [27:24] dr, [23:20] sr1, [19:16] sr2, [15:0] imm.
- Immediate form: op[3]=1; sr2 is unused and outB = imm.
- Writes a register: every op except OP_STORE (4'hB) and OP_BRANCH (4'hC).
- Load: OP_LOAD (4'hA).
- Reads sr1: all ops. Reads sr2: register-form ops plus OP_STORE.
- Register file reads are combinational; operands are captured on the accepting edge, so latency is 1 cycle in to out.
- Bypass: a used source equal to dr while wrtEn=1 takes dIn instead of sr1Out/sr2Out.
- Scoreboard: pending[REG_SIZE], reset to 0.
  - Set: pending[dr_field] is set when a load is accepted.
  - Clear: pending[dr] is cleared when wrtEn=1.
  - Same register set and cleared in one cycle: set wins.
- Hazard = inValid && a used source is pending && not (wrtEn && dr==that source).
- inReady = (!outValid || outReady) && !hazard. An accept occurs when inValid && inReady.
- On accept: all out* fields load and outValid=1.
- Execute drains without a new accept (outValid && outReady): outValid=0.
- Execute not ready (outValid && !outReady): all out* hold stable.
- flush: outValid=0 next edge, no accept that cycle (inReady=0). Scoreboard unaffected, because in-flight loads still write back.
- Reset, including mid-operation: outValid=0, all out* data=0, pending=0, inReady=1 once released.
- Register 0 is not special.

Optional Feature:
- BYPASS_EN defined: write-through bypass as above.
- BYPASS_EN undefined: no bypass. Any used source matching dr with wrtEn=1 counts as a hazard, giving a 1-cycle stall; the operand is read after the register file write completes.
- Scoreboard behaviour is the same in both builds.

Decomposition:
- Shared package holds:
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH;
  - field bit positions;
  - instruction-field typedef;
  - helper functions usesSr2(op) and writesDr(op).
- One sub-module, pending_scoreboard: set/clear ports plus a two-address busy lookup.

Test Plan:
- Reg-form add, op=4'h1 dr=3 sr1=1 sr2=2, reg file r1=5 r2=7, outReady=1 -> next cycle outValid=1, outA=5, outB=7, outDr=3, outWrtEn=1.
- Immediate op=4'h9 imm=16'hFFFE -> outB=outImm=32'hFFFFFFFE; sr2 ignored.
- Bypass: reading r4 while wrtEn=1 dr=4 dIn=0xDEAD, sr1Out=0 -> outA=0xDEAD. With BYPASS_EN off: inReady=0 for 1 cycle, then outA=0xDEAD.
- Load to r6, then a consumer of r6 -> inReady=0 until wrtEn dr=6. The same-cycle release captures the bypassed dIn, and pending[6] clears.
- outReady=0 for 3 cycles with outValid=1 -> outputs stable, inReady=0; an accept occurs on the cycle outReady returns to 1.
- Load accepted, then reset_n pulsed low mid-stream -> outValid=0 and pending=0 immediately; no stall afterwards on r6.
